cpc_bus_initiator: RTL and testbench

Z80-style bus cycle generator that drives CPC expansion-bus memory and I/O cycles from a simple command/response interface. It is the initiator side of the bus that the RAM expansion board responds to. It issues I/O writes to port &7Fxx to program the RAM block register, and memory reads and writes to exercise the banked SRAM. It is used in the board test jig CPLD and in the bench as the bus master.

---
 rtl/cpc_bus_pkg.sv | 20 ++
 rtl/cpc_bus_initiator_if.sv | 28 ++
 rtl/cpc_wait_counter.sv | 52 +++++
 rtl/cpc_bus_initiator.sv | 126 ++++++++++++
 tb/tb_cpc_bus_initiator.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cpc_bus_pkg.sv
// Shared encodings for the CPC expansion-bus initiator: ops, FSM states, RAM config port.
package cpc_bus_pkg;
  typedef enum logic [1:0] {
    OP_MEM_RD = 2'b00,
    OP_MEM_WR = 2'b01,
    OP_IO_RD  = 2'b10,
    OP_IO_WR  = 2'b11
  } cpc_op_e;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_TW   = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // RAM block register lives at &7Fxx; data bits 7:6 = 11 select it.
  localparam logic [7:0] RAMCFG_PORT_HI = 8'h7F;
  localparam logic [1:0] RAMCFG_CMD     = 2'b11;
endpackage

// File: rtl/cpc_bus_initiator_if.sv
// Command/response and Z80-style bus signals of the CPC initiator.
interface cpc_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] A;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  D_in;
  logic        MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B;
  logic        READY;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, D_in, READY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           A, D_out, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, D_in, READY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           A, D_out, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B
  );
endinterface

// File: rtl/cpc_wait_counter.sv
// Wait-state bookkeeping: fixed TW countdown, TW cycle count and timeout compare.
module cpc_wait_counter #(
  parameter int MEM_WAIT     = 0,
  parameter int IO_WAIT      = 1,
  parameter int WAIT_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  input  logic is_io,
  input  logic ready,
  output logic wait_done,
  output logic timeout
);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(WAIT_TIMEOUT);
  localparam logic [TO_W-1:0] MEM_FIX = TO_W'(MEM_WAIT);
  localparam logic [TO_W-1:0] IO_FIX  = TO_W'(IO_WAIT);

  logic [TO_W-1:0] fix_q, fix_d, tw_q, tw_d;
  logic            ready_eff;

  // Decisions use the post-decrement count so a fixed count of N yields N TW states.
  always_comb begin
    ready_eff = ready || (WAIT_TIMEOUT == 0);
    fix_d     = fix_q;
    tw_d      = tw_q;
    wait_done = 1'b0;
    timeout   = 1'b0;
    if (load) begin
      fix_d     = is_io ? IO_FIX : MEM_FIX;
      tw_d      = '0;
      wait_done = (fix_d == '0) && ready_eff;
    end else if (tick) begin
      fix_d     = (fix_q != '0) ? fix_q - 1'b1 : fix_q;
      tw_d      = tw_q + 1'b1;
      wait_done = (fix_d == '0) && ready_eff;
      timeout   = !wait_done && (WAIT_TIMEOUT != 0) && (tw_d == TO_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fix_q <= '0;
      tw_q  <= '0;
    end else begin
      fix_q <= fix_d;
      tw_q  <= tw_d;
    end
  end
endmodule

// File: rtl/cpc_bus_initiator.sv
// Z80-style CPC expansion-bus cycle generator driven by a command/response handshake.
module cpc_bus_initiator import cpc_bus_pkg::*; #(
  parameter int MEM_WAIT     = 0,
  parameter int IO_WAIT      = 1,
  parameter int WAIT_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  cpc_bus_initiator_if.master  bus
);
  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  dout_q, dout_d, rdata_q, rdata_d;
  logic        doe_q, doe_d;
  logic        mreq_q, mreq_d, ioreq_q, ioreq_d, rd_q, rd_d, wr_q, wr_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d, to_flag_q, to_flag_d;
  logic        accept, strobe_on, wait_done, wait_to;

  assign bus.cmd_ready = (state_q == ST_IDLE) && RESET_B;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  cpc_wait_counter #(
    .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .WAIT_TIMEOUT(WAIT_TIMEOUT), .TO_W(TO_W)
  ) u_wait (
    .clk(CLK), .rst_n(RESET_B),
    .load(state_q == ST_T2), .tick(state_q == ST_TW),
    .is_io(op_q[1]), .ready(bus.READY),
    .wait_done(wait_done), .timeout(wait_to)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    dout_d    = dout_q;
    doe_d     = doe_q;
    rdata_d   = rdata_q;
    to_flag_d = to_flag_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d   = ST_T1;
        op_d      = bus.cmd_op;
        a_d       = bus.cmd_addr;
        to_flag_d = 1'b0;
        if (bus.cmd_op[0]) begin
          dout_d = bus.cmd_wdata;
          doe_d  = 1'b1;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2, ST_TW: begin
        if (wait_done || wait_to) begin
          state_d   = ST_T3;
          to_flag_d = wait_to;
        end else begin
          state_d = ST_TW;
        end
      end
      ST_T3: begin
        state_d = ST_DONE;
        if (!op_q[0]) rdata_d = bus.D_in;
      end
      // Write data stays on the bus through DONE for hold time.
      ST_DONE: begin
        state_d = ST_IDLE;
        doe_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    strobe_on   = (state_d == ST_T2) || (state_d == ST_TW) || (state_d == ST_T3);
    mreq_d      = !(strobe_on && !op_d[1]);
    ioreq_d     = !(strobe_on &&  op_d[1]);
    rd_d        = !(strobe_on && !op_d[0]);
    wr_d        = !(strobe_on &&  op_d[0]);
    rsp_valid_d = (state_d == ST_DONE);
    rsp_to_d    = (state_d == ST_DONE) && to_flag_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      rdata_q     <= '0;
      to_flag_q   <= 1'b0;
      mreq_q      <= 1'b1;
      ioreq_q     <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      rdata_q     <= rdata_d;
      to_flag_q   <= to_flag_d;
      mreq_q      <= mreq_d;
      ioreq_q     <= ioreq_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign bus.A           = a_q;
  assign bus.D_out       = dout_q;
  assign bus.D_oe        = doe_q;
  assign bus.MREQ_B      = mreq_q;
  assign bus.IOREQ_B     = ioreq_q;
  assign bus.RD_B        = rd_q;
  assign bus.WR_B        = wr_q;
  assign bus.M1_B        = 1'b1;
  assign bus.RFSH_B      = 1'b1;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_timeout = rsp_to_q;
endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed bench for cpc_bus_initiator: handshake, strobe timing, waits, timeout, reset abort.
module tb_cpc_bus_initiator;
  import cpc_bus_pkg::*;

  logic CLK, RESET_B;
  int   checks = 0, failures = 0;
  cpc_bus_initiator_if bus_if ();

  cpc_bus_initiator #(.MEM_WAIT(0), .IO_WAIT(1), .WAIT_TIMEOUT(16), .TO_W(5)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .bus(bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM expansion block register model
  logic [2:0] ram_block = 3'd7;
  always @(posedge CLK)
    if (!bus_if.IOREQ_B && !bus_if.WR_B && bus_if.A[15:8] == RAMCFG_PORT_HI &&
        bus_if.D_out[7:6] == RAMCFG_CMD)
      ram_block <= bus_if.D_out[2:0];

  int lat, mreq_lo, ioreq_lo, rd_lo, wr_lo, doe_n, a_bad, dout_bad, overlap = 0;
  logic [7:0] got_rdata;
  logic       got_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd);
    bus_if.cmd_op    = op;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wd;
    bus_if.cmd_valid = 1'b1;
    for (int k = 0; k < 20 && !bus_if.cmd_ready; k++) tick;
    chk("accept_ready", bus_if.cmd_ready, 1);
    tick;
    bus_if.cmd_valid = 1'b0;
  endtask

  // Cycle i=1 is T1; READY is driven low for cycles [lo_start, lo_start+lo_len).
  task automatic observe(input int lo_start, input int lo_len,
                         input logic [15:0] exp_a, input logic [7:0] exp_d);
    lat = 0; mreq_lo = 0; ioreq_lo = 0; rd_lo = 0; wr_lo = 0;
    doe_n = 0; a_bad = 0; dout_bad = 0; got_to = 1'bx; got_rdata = 8'hxx;
    for (int i = 1; i <= 100; i++) begin
      bus_if.READY = !(i >= lo_start && i < lo_start + lo_len);
      if (!bus_if.MREQ_B)  mreq_lo++;
      if (!bus_if.IOREQ_B) ioreq_lo++;
      if (!bus_if.RD_B)    rd_lo++;
      if (!bus_if.WR_B)    wr_lo++;
      if (bus_if.D_oe) begin
        doe_n++;
        if (bus_if.D_out !== exp_d) dout_bad++;
      end
      if (bus_if.A !== exp_a) a_bad++;
      if ((!bus_if.MREQ_B && !bus_if.IOREQ_B) || (!bus_if.RD_B && !bus_if.WR_B)) overlap++;
      if (bus_if.rsp_valid) begin
        lat = i;
        got_to = bus_if.rsp_timeout;
        got_rdata = bus_if.rsp_rdata;
        tick;
        break;
      end
      tick;
    end
    bus_if.READY = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc [3] = '{0, 0, 0};
  int n, rsp_n, idle_bad, rv;

  initial begin
    RESET_B = 1'b0;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_op = 2'b00; bus_if.cmd_addr = '0;
    bus_if.cmd_wdata = '0; bus_if.D_in = '0; bus_if.READY = 1'b1;
    tick; tick;

    // Reset state
    chk("rst_A", bus_if.A, 0);
    chk("rst_dout", bus_if.D_out, 0);
    chk("rst_doe", bus_if.D_oe, 0);
    chk("rst_strobes", {bus_if.MREQ_B, bus_if.IOREQ_B, bus_if.RD_B, bus_if.WR_B,
                        bus_if.M1_B, bus_if.RFSH_B}, 6'h3F);
    chk("rst_rsp", {bus_if.rsp_valid, bus_if.rsp_timeout}, 0);
    chk("rst_rdata", bus_if.rsp_rdata, 0);
    chk("rst_cmd_ready", bus_if.cmd_ready, 0);
    RESET_B = 1'b1;
    tick;

    // 1: memory write, no waits
    issue(OP_MEM_WR, 16'h4000, 8'h55);
    observe(0, 0, 16'h4000, 8'h55);
    chk("t1_mreq_lo", mreq_lo, 2);
    chk("t1_wr_lo", wr_lo, 2);
    chk("t1_other_lo", ioreq_lo + rd_lo, 0);
    chk("t1_doe_cycles", doe_n, 4);
    chk("t1_dout", dout_bad, 0);
    chk("t1_latency", lat, 4);
    chk("t1_timeout", got_to, 0);
    chk("t1_rsp_one_cycle", bus_if.rsp_valid, 0);
    chk("t1_idle_doe", bus_if.D_oe, 0);
    chk("t1_idle_ready", bus_if.cmd_ready, 1);

    // 2: I/O write to RAM config port, one automatic wait
    issue(OP_IO_WR, 16'h7FC4, 8'hC4);
    observe(0, 0, 16'h7FC4, 8'hC4);
    chk("t2_ioreq_lo", ioreq_lo, 3);
    chk("t2_wr_lo", wr_lo, 3);
    chk("t2_mreq_lo", mreq_lo, 0);
    chk("t2_addr_held", a_bad, 0);
    chk("t2_latency", lat, 5);
    chk("t2_ram_block", ram_block, 3'd4);

    // 3: memory read stretched by READY for three cycles
    bus_if.D_in = 8'hA7;
    issue(OP_MEM_RD, 16'h8000, 8'h00);
    observe(2, 3, 16'h8000, 8'h00);
    chk("t3_rd_lo", rd_lo, 5);
    chk("t3_mreq_lo", mreq_lo, 5);
    chk("t3_doe", doe_n, 0);
    chk("t3_latency", lat, 7);
    chk("t3_rdata", got_rdata, 8'hA7);
    chk("t3_timeout", got_to, 0);

    // 4: READY stuck low -> timeout after 16 TW, then a normal I/O read
    bus_if.D_in = 8'h3C;
    issue(OP_MEM_RD, 16'h8001, 8'h00);
    observe(2, 1000, 16'h8001, 8'h00);
    chk("t4_latency", lat, 20);
    chk("t4_rd_lo", rd_lo, 18);
    chk("t4_timeout", got_to, 1);
    chk("t4_rdata", got_rdata, 8'h3C);
    bus_if.D_in = 8'h5A;
    issue(OP_IO_RD, 16'h7F00, 8'h00);
    observe(0, 0, 16'h7F00, 8'h00);
    chk("t4b_latency", lat, 5);
    chk("t4b_timeout", got_to, 0);
    chk("t4b_rdata", got_rdata, 8'h5A);
    chk("t4b_ioreq_lo", ioreq_lo, 3);

    // 5: reset during TW of an I/O write
    issue(OP_IO_WR, 16'h7FC0, 8'hC0);
    tick; tick;
    chk("t5_in_tw", bus_if.IOREQ_B, 0);
    RESET_B = 1'b0;
    tick;
    chk("t5_strobes", {bus_if.MREQ_B, bus_if.IOREQ_B, bus_if.RD_B, bus_if.WR_B}, 4'hF);
    chk("t5_doe", bus_if.D_oe, 0);
    chk("t5_rsp", bus_if.rsp_valid, 0);
    chk("t5_ready_in_rst", bus_if.cmd_ready, 0);
    tick;
    RESET_B = 1'b1;
    tick;
    chk("t5_ready_after", bus_if.cmd_ready, 1);
    rv = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus_if.rsp_valid) rv++;
      tick;
    end
    chk("t5_no_rsp", rv, 0);

    // 6: cmd_valid held high across three writes
    n = 0; rsp_n = 0; idle_bad = 0;
    bus_if.cmd_op = OP_MEM_WR; bus_if.cmd_addr = 16'h0100; bus_if.cmd_wdata = 8'h11;
    bus_if.cmd_valid = 1'b1;
    for (int c = 0; c < 60 && rsp_n < 3; c++) begin
      if (bus_if.rsp_valid) rsp_n++;
      if (bus_if.cmd_ready && bus_if.cmd_valid) begin
        if (!(&{bus_if.MREQ_B, bus_if.IOREQ_B, bus_if.RD_B, bus_if.WR_B}) || bus_if.D_oe)
          idle_bad++;
        acc[n] = c;
        n++;
        tick;
        if (n < 3) begin
          bus_if.cmd_addr  = 16'h0100 + 16'(n);
          bus_if.cmd_wdata = (n == 1) ? 8'h22 : 8'h33;
        end else begin
          bus_if.cmd_valid = 1'b0;
        end
      end else begin
        tick;
      end
    end
    chk("t6_accepts", n, 3);
    chk("t6_rsps", rsp_n, 3);
    chk("t6_gap01", acc[1] - acc[0], 5);
    chk("t6_gap12", acc[2] - acc[1], 5);
    chk("t6_idle_strobes", idle_bad, 0);

    chk("strobe_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
